// File: rtl/btn_if.sv
// Button bundle between the board pins and the timer front end.
// Pulse semantics: btn_press / btn_release are single-cycle, active-high
// event strobes with no back-pressure; a consumer must sample them every
// cycle. btn_level is a plain level. rep_state exposes each lane's repeat
// FSM state (2 bits per lane, lane i at [2*i +: 2]) for observation.
interface btn_if #(
  parameter int N_BTN = 5
) ();
  logic [N_BTN-1:0]   btn_raw;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_press;
  logic [N_BTN-1:0]   btn_release;
  logic               btn_any;
  logic [2*N_BTN-1:0] rep_state;

  // Board/consumer side: drives the raw pins, observes conditioned events.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_any, rep_state
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_any, rep_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Pushbutton front end: per lane 2-flop sync -> debounce -> level ->
// press/release pulses, with optional auto-repeat on held buttons.
// Lanes are fully independent; every output is registered.
module button_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 50000000,
  parameter int               REPEAT_RATE     = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00011
) (
  input logic  clk,
  input logic  rst,
  btn_if.slave bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_nxt_v;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic             any_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    localparam bit REP_EN = REPEAT_MASK[i];

    logic          s1, s2;
    logic          lvl, lvl_d, lvl_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          press, rel;
    logic          rise, fall;
    rep_state_e    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          fire;

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
      dcnt_nxt = dcnt;
      lvl_nxt  = lvl;
      if (s2 == lvl) begin
        dcnt_nxt = '0;
      end else if (dcnt == DEB_LAST) begin
        lvl_nxt  = s2;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt + DW'(1);
      end
    end

    // rise/fall are seen one edge after the level register changes.
    assign rise = lvl & ~lvl_d;
    assign fall = lvl_d & ~lvl;

    // Sync chain, debounce state and registered event pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        dcnt  <= '0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        s1    <= bus.btn_raw[i];
        s2    <= s1;
        dcnt  <= dcnt_nxt;
        lvl   <= lvl_nxt;
        lvl_d <= lvl;
        press <= rise | fire;
        rel   <= fall;
      end
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // Repeat FSM next state: delay after the press, then a fixed rate until release.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      if (!REP_EN) begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state_nxt = DELAY;
              rcnt_nxt  = '0;
            end
          end
          DELAY: begin
            if (fall) begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end else if (rcnt == DELAY_LAST) begin
              state_nxt = REPEAT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          REPEAT: begin
            if (fall) begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end else if (rcnt == RATE_LAST) begin
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end
    end

    // Repeat FSM output: a repeat strobe, never on the release edge.
    always_comb begin
      fire = 1'b0;
      if (REP_EN && !fall) begin
        if (state == DELAY && rcnt == DELAY_LAST) fire = 1'b1;
        if (state == REPEAT && rcnt == RATE_LAST) fire = 1'b1;
      end
    end

    assign level_q[i]               = lvl;
    assign level_nxt_v[i]           = lvl_nxt;
    assign press_q[i]               = press;
    assign release_q[i]             = rel;
    assign bus.rep_state[2*i +: 2]  = state;
  end

  // btn_any follows the level registers in the same cycle, so it is built from their next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |level_nxt_v;
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_any     = any_q;

endmodule
